operand_queue: RTL and testbench

- Elastic operand buffer directly downstream of the PE's 12-input operand selector; captures the selected token and presents it to the PE ALU operand port.
- Decouples neighbour/constant arrival timing from ALU firing using valid/ready handshakes on both sides.
- Supports a sticky "reuse" mode: a loop-invariant operand is consumed repeatedly without being popped.

---
 rtl/operand_queue_if.sv | 30 +++
 rtl/operand_queue.sv | 80 ++++++++
 tb/tb_operand_queue.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_queue_if.sv
// operand_queue_if: valid/ready handshakes around the PE operand queue.
// Upstream side carries selector tokens, downstream side feeds the ALU port.
interface operand_queue_if #(
    parameter int DATA_SIZE = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/operand_queue.sv
// operand_queue: elastic FWFT operand buffer between selector and ALU.
// Sticky reuse keeps a loop-invariant head alive across handshakes.
module operand_queue #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_queue_if.slave         q_if,
    input  logic                   flush,
    input  logic                   reuse,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q;
    logic [PW-1:0]        rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        wr_ptr_d;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 push;
    logic                 pop;

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready depends on registered count only, never on out_ready
    assign q_if.in_ready  = !full;
    assign q_if.out_valid = !empty;
    assign q_if.out_data  = empty ? '0 : mem_q[rd_ptr_q];

    assign push = q_if.in_valid && !full;
    assign pop  = !empty && q_if.out_ready && !reuse;

    // Next pointers and occupancy; flush wins over push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; dropped under reset or flush, never when full
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem_q[wr_ptr_q] <= q_if.in_data;
        end
    end
endmodule

// File: tb/tb_operand_queue.sv
// tb_operand_queue: directed stimulus with a queue-based reference model.
// Every cycle after reset the DUT outputs are compared against the model.
module tb_operand_queue;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       reuse;
    logic [2:0] count;
    logic       full;
    logic       empty;

    operand_queue_if #(.DATA_SIZE(DW)) bus ();

    operand_queue #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (bus),
        .flush (flush),
        .reuse (reuse),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    // reference model: plain FIFO of tokens
    logic [DW-1:0] mq[$];
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    bit  lit_en = 1'b0;
    logic [DW-1:0] lit_data;
    int  lit_cnt;

    always @(posedge clk) begin
        int sz;
        bit do_push;
        bit do_pop;
        sz = mq.size();
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            do_push = bus.in_valid && (sz < DEPTH);
            do_pop  = (sz > 0) && bus.out_ready && !reuse;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(bus.in_data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int sz;
        if (chk_en) begin
            sz = mq.size();
            chk("count", int'(count), sz);
            chk("out_valid", int'(bus.out_valid), int'(sz != 0));
            chk("out_data", int'(bus.out_data), (sz != 0) ? int'(mq[0]) : 0);
            chk("in_ready", int'(bus.in_ready), int'(sz != DEPTH));
            chk("full", int'(full), int'(sz == DEPTH));
            chk("empty", int'(empty), int'(sz == 0));
            if (lit_en) begin
                chk("lit_data", int'(bus.out_data), int'(lit_data));
                chk("lit_count", int'(count), lit_cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic expect_now(input logic [DW-1:0] d, input int c);
        lit_data = d;
        lit_cnt  = c;
        lit_en   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        reuse = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();

        // single token, held, then popped
        rst_n = 1'b1;
        expect_now(8'h00, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        cyc();
        bus.in_valid = 1'b0;
        expect_now(8'h5A, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_now(8'h5A, 1);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        expect_now(8'h00, 0);

        // fill to full, hold off 5th token, drain in order
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 8'(i);
            cyc();
        end
        bus.in_data = 8'h05;
        expect_now(8'h01, 4);
        cyc();
        expect_now(8'h01, 4);
        bus.out_ready = 1'b1;
        cyc();
        expect_now(8'h02, 3);
        cyc();
        expect_now(8'h03, 3);
        bus.in_valid = 1'b0;
        cyc();
        expect_now(8'h04, 2);
        cyc();
        expect_now(8'h05, 1);
        cyc();
        expect_now(8'h00, 0);

        // streaming push and pop, pointers wrap
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'(8'h10 + i);
            cyc();
            expect_now(8'(8'h10 + i), 1);
        end
        bus.in_valid = 1'b0;
        cyc();
        expect_now(8'h00, 0);
        bus.out_ready = 1'b0;

        // sticky reuse of the head
        reuse = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        cyc();
        expect_now(8'h33, 1);
        bus.in_data = 8'h44;
        cyc();
        expect_now(8'h33, 2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            expect_now(8'h33, 2);
        end
        reuse = 1'b0;
        cyc();
        expect_now(8'h44, 1);
        cyc();
        expect_now(8'h00, 0);
        bus.out_ready = 1'b0;

        // flush drops a same-cycle push and pop
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = 8'(8'h20 + i);
            cyc();
        end
        expect_now(8'h21, 3);
        flush = 1'b1;
        bus.in_data   = 8'h77;
        bus.out_ready = 1'b1;
        cyc();
        expect_now(8'h00, 0);
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = 8'h88;
        cyc();
        bus.in_valid = 1'b0;
        expect_now(8'h88, 1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        expect_now(8'h00, 0);

        // reset mid-operation with reuse active
        reuse = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_data = 8'(8'h60 + i);
            cyc();
        end
        expect_now(8'h61, 3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        expect_now(8'h00, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        cyc();
        bus.in_valid = 1'b0;
        expect_now(8'h99, 1);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
